// File: rtl/sum_window_acc_if.sv
// Handshake bundle between the input-buffer adder, the window accumulator and the next DSP stage.
// The master drives samples and out_ready. The slave is the accumulator.
interface sum_window_acc_if #(
   parameter int unsigned N        = 10,
   parameter int unsigned WIN_LOG2 = 3
);
   localparam int unsigned ACC_W = N + 1 + WIN_LOG2;
   localparam int unsigned CNT_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;

   logic             clr;
   logic             in_valid;
   logic [N-1:0]     in_sum;
   logic             in_co;
   logic             in_ready;
   logic             out_valid;
   logic [ACC_W-1:0] out_data;
   logic             out_ready;
   logic [CNT_W-1:0] win_cnt;

   modport master (
      output clr, in_valid, in_sum, in_co, out_ready,
      input  in_ready, out_valid, out_data, win_cnt
   );

   modport slave (
      input  clr, in_valid, in_sum, in_co, out_ready,
      output in_ready, out_valid, out_data, win_cnt
   );
endinterface

// File: rtl/sum_window_acc.sv
// Accumulates 2^WIN_LOG2 adder samples ({co,sum}) per window and hands each result downstream
// through a valid/ready register. When SUM_WINDOW_AVG_EN is defined, the result is the rounded mean.
module sum_window_acc #(
   parameter int unsigned N        = 10,
   parameter int unsigned WIN_LOG2 = 3
) (
   input logic             clk,
   input logic             rst_n,
   sum_window_acc_if.slave bus
);
   localparam int unsigned ACC_W = N + 1 + WIN_LOG2;
   localparam int unsigned CNT_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
   localparam logic [CNT_W-1:0] CntLast = CNT_W'((1 << WIN_LOG2) - 1);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] sum, result;
   logic             last, accept, complete;

   // With WIN_LOG2 = 0 the counter never leaves 0, so every sample is the last one.
   assign last     = (cnt_q == CntLast);
   assign bus.in_ready = ~last | ~out_valid_q | bus.out_ready;
   assign accept   = bus.in_valid & bus.in_ready;
   assign complete = accept & last & ~bus.clr;
   assign sum      = acc_q + ACC_W'({bus.in_co, bus.in_sum});

`ifdef SUM_WINDOW_AVG_EN
   localparam int unsigned RND_W = ACC_W + 1;
   localparam logic [RND_W-1:0] RoundAdd = RND_W'((1 << WIN_LOG2) >> 1);
   logic [RND_W-1:0] sum_rnd;
   assign sum_rnd = {1'b0, sum} + RoundAdd;
   assign result  = ACC_W'(sum_rnd >> WIN_LOG2);
`else
   assign result = sum;
`endif

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      // clr drops the partial window and any sample accepted alongside it.
      if (bus.clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         if (last) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (complete) begin
         out_valid_d = 1'b1;
         out_data_d  = result;
      end else if (out_valid_q & bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.win_cnt   = cnt_q;
endmodule

// File: tb/tb_sum_window_acc.sv
// Bench for sum_window_acc: an 8-sample window instance and a 1-sample instance,
// checked every cycle against a sample-count/running-sum reference model.
module tb_sum_window_acc;
   localparam int unsigned N    = 10;
   localparam int unsigned WL_A = 3;
   localparam int unsigned WL_B = 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sum_window_acc_if #(.N(N), .WIN_LOG2(WL_A)) bus_a ();
   sum_window_acc_if #(.N(N), .WIN_LOG2(WL_B)) bus_b ();

   sum_window_acc #(.N(N), .WIN_LOG2(WL_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   sum_window_acc #(.N(N), .WIN_LOG2(WL_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   logic         drv_clr[2];
   logic         drv_valid[2];
   logic [N-1:0] drv_sum[2];
   logic         drv_co[2];
   logic         drv_oready[2];

   longint unsigned obs_ready[2], obs_valid[2], obs_data[2], obs_cnt[2];

   assign bus_a.clr       = drv_clr[0];
   assign bus_a.in_valid  = drv_valid[0];
   assign bus_a.in_sum    = drv_sum[0];
   assign bus_a.in_co     = drv_co[0];
   assign bus_a.out_ready = drv_oready[0];
   assign bus_b.clr       = drv_clr[1];
   assign bus_b.in_valid  = drv_valid[1];
   assign bus_b.in_sum    = drv_sum[1];
   assign bus_b.in_co     = drv_co[1];
   assign bus_b.out_ready = drv_oready[1];

   always_comb begin
      obs_ready[0] = 64'(bus_a.in_ready);
      obs_valid[0] = 64'(bus_a.out_valid);
      obs_data[0]  = 64'(bus_a.out_data);
      obs_cnt[0]   = 64'(bus_a.win_cnt);
      obs_ready[1] = 64'(bus_b.in_ready);
      obs_valid[1] = 64'(bus_b.out_valid);
      obs_data[1]  = 64'(bus_b.out_data);
      obs_cnt[1]   = 64'(bus_b.win_cnt);
   end

   // Reference model: samples taken so far in the window, their sum, and the pending result.
   int unsigned     win[2] = '{8, 1};
   int unsigned     m_cnt[2];
   longint unsigned m_sum[2];
   bit              m_valid[2];
   longint unsigned m_data[2];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic longint unsigned win_result(input longint unsigned s, input int unsigned w);
`ifdef SUM_WINDOW_AVG_EN
      return (s + w / 2) / w;
`else
      return s + 0 * w;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]   = 0;
         m_sum[i]   = 0;
         m_valid[i] = 1'b0;
         m_data[i]  = 0;
      end
   endtask

   task automatic idle();
      for (int i = 0; i < 2; i++) begin
         drv_clr[i]   = 1'b0;
         drv_valid[i] = 1'b0;
         drv_sum[i]   = '0;
         drv_co[i]    = 1'b0;
      end
   endtask

   task automatic put(input int i, input logic v, input longint unsigned x);
      drv_valid[i] = v;
      drv_sum[i]   = N'(x);
      drv_co[i]    = x[N];
   endtask

   // One clock: check in_ready and advance the model before the edge, check registers after it.
   task automatic cycle();
      #1;
      for (int i = 0; i < 2; i++) begin
         bit              er, acc, done;
         longint unsigned x;
         er = (m_cnt[i] != win[i] - 1) || !m_valid[i] || drv_oready[i];
         check($sformatf("in_ready[%0d]", i), obs_ready[i], 64'(er));
         acc  = drv_valid[i] && er;
         x    = 64'({drv_co[i], drv_sum[i]});
         done = 1'b0;
         if (drv_clr[i]) begin
            m_cnt[i] = 0;
            m_sum[i] = 0;
         end else if (acc) begin
            if (m_cnt[i] == win[i] - 1) begin
               done      = 1'b1;
               m_data[i] = win_result(m_sum[i] + x, win[i]);
               m_cnt[i]  = 0;
               m_sum[i]  = 0;
            end else begin
               m_cnt[i]++;
               m_sum[i] += x;
            end
         end
         if (done) m_valid[i] = 1'b1;
         else if (m_valid[i] && drv_oready[i]) m_valid[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("out_valid[%0d]", i), obs_valid[i], 64'(m_valid[i]));
         check($sformatf("out_data[%0d]", i), obs_data[i], m_data[i]);
         check($sformatf("win_cnt[%0d]", i), obs_cnt[i], 64'(m_cnt[i]));
      end
   endtask

   initial begin
      int unsigned seen;
      longint unsigned seen_data;
      idle();
      drv_oready[0] = 1'b1;
      drv_oready[1] = 1'b1;
      rst_n = 1'b0;
      model_reset();
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_valid", obs_valid[0], 0);
      check("reset_cnt", obs_cnt[0], 0);

      // Reset mid-window after 3 samples.
      for (int k = 0; k < 3; k++) begin put(0, 1'b1, 9); cycle(); end
      idle();
      rst_n = 1'b0;
      #2;
      model_reset();
      check("midrst_valid", obs_valid[0], 0);
      check("midrst_data", obs_data[0], 0);
      check("midrst_cnt", obs_cnt[0], 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin put(0, 1'b1, 5); cycle(); end
      check("sum40", obs_data[0], win_result(40, 8));
      idle();
      cycle();

      // Maximum sample values.
      for (int k = 0; k < 8; k++) begin put(0, 1'b1, 2047); cycle(); end
      check("max_valid", obs_valid[0], 1);
      check("max_data", obs_data[0], win_result(16376, 8));
      idle();
      cycle();

      // Back-pressure on the last sample of a window.
      drv_oready[0] = 1'b0;
      for (int k = 0; k < 15; k++) begin put(0, 1'b1, 1); cycle(); end
      check("bp_cnt7", obs_cnt[0], 7);
      for (int k = 0; k < 3; k++) begin
         #1 check("bp_stall", obs_ready[0], 0);
         cycle();
      end
      drv_oready[0] = 1'b1;
      #1 check("bp_release", obs_ready[0], 1);
      cycle();
      check("bp_valid", obs_valid[0], 1);
      check("bp_data", obs_data[0], win_result(8, 8));

      // clr coincident with an accepted sample at win_cnt = 4.
      drv_oready[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin put(0, 1'b1, 2); cycle(); end
      check("clr_pre_cnt", obs_cnt[0], 4);
      drv_clr[0] = 1'b1;
      put(0, 1'b1, 100);
      cycle();
      idle();
      check("clr_cnt", obs_cnt[0], 0);
      check("clr_valid", obs_valid[0], 1);
      check("clr_data", obs_data[0], win_result(8, 8));

      // Gapped input 1..8.
      drv_oready[0] = 1'b1;
      seen = 0;
      seen_data = 0;
      for (int k = 0; k < 18; k++) begin
         if (k < 16) put(0, (k % 2) == 0, longint'(k / 2 + 1));
         else idle();
         cycle();
         if (obs_valid[0] != 0) begin seen++; seen_data = obs_data[0]; end
      end
      check("gap_once", 64'(seen), 1);
      check("gap_data", seen_data, win_result(36, 8));

      // Single-sample window instance: 3, 7, 9.
      idle();
      foreach (drv_oready[i]) drv_oready[i] = 1'b1;
      begin
         longint unsigned vals[3] = '{3, 7, 9};
         for (int k = 0; k < 3; k++) begin
            put(1, 1'b1, vals[k]);
            cycle();
            check("w0_valid", obs_valid[1], 1);
            check("w0_data", obs_data[1], vals[k]);
         end
      end
      idle();
      cycle();

      // Randomized traffic on both instances.
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < 2; i++) begin
            put(i, $urandom_range(0, 3) != 0, longint'($urandom_range(0, 2047)));
            drv_oready[i] = $urandom_range(0, 2) != 0;
            drv_clr[i]    = $urandom_range(0, 24) == 0;
         end
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sum_window_acc.md
Name: sum_window_acc

Overview:
- Downstream stage of the input-buffer adder. Consumes the adder's N-bit sum and carry-out as one (N+1)-bit value per valid sample.
- Accumulates 2^WIN_LOG2 consecutive values into a window sum.
- Presents each window sum through a valid/ready output register to the next DSP stage.
- Back-pressures the adder side only when a finished window cannot be delivered.

Parameters:
- N, 10: width of the adder sum input.
- WIN_LOG2, 3: log2 of the window length; WIN = 2^WIN_LOG2; legal range 0..8.
- ACC_W, derived as N+1+WIN_LOG2 (localparam, not overridable): accumulator and output width.

Ports:
- clk  in  1  system clock; all registers rise-edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous window clear.
- in_valid  in  1  sample present on in_sum/in_co.
- in_sum  in  N  adder sum bits.
- in_co  in  1  adder carry-out; MSB of the sample value.
- in_ready  out  1  sample accepted this cycle when in_valid & in_ready.
- out_valid  out  1  out_data holds a completed window result.
- out_data  out  ACC_W  window result.
- out_ready  in  1  downstream accepts out_data.
- win_cnt  out  max(WIN_LOG2,1)  samples accumulated in the current window.

Behaviour:
- Reset (rst_n low, async): acc=0, cnt=0, out_valid=0, out_data=0, win_cnt=0. Reset mid-window discards the partial window and any undelivered result.
- Sample value x = {in_co, in_sum}, zero-extended to ACC_W. Unsigned arithmetic. No overflow is possible: max window sum is (2^(N+1)-1)*WIN < 2^ACC_W.
- accept = in_valid & in_ready.
- in_ready = 1 when cnt != WIN-1.
- When cnt == WIN-1, in_ready = ~out_valid | out_ready. The combinational path from out_ready to in_ready is allowed.
- Window states:
  - FILL (cnt < WIN-1): on accept, acc <= acc + x and cnt <= cnt+1.
  - LAST (cnt == WIN-1): on accept, out_data <= acc + x, out_valid <= 1, acc <= 0, cnt <= 0.
- Latency: result visible on out_data/out_valid the cycle after the final sample is accepted.
- Output register:
  - Cleared (out_valid <= 0) on out_valid & out_ready when no new completion occurs that cycle.
  - If a new completion and a drain happen in the same cycle, the register reloads and out_valid stays 1.
  - out_data holds its value while out_valid & ~out_ready.
- WIN_LOG2 = 0:
  - Every accepted sample completes a window; cnt and win_cnt are tied to 0.
  - Behaves as a 1-deep registered pipeline stage.
  - in_ready = ~out_valid | out_ready.
- cnt wraps WIN-1 -> 0 only via completion. No other wrap exists.
- clr (sync): acc <= 0 and cnt <= 0. Any sample accepted in the same cycle is discarded (clr wins). The output register and out_valid are unaffected.
- in_ready is still computed normally during clr.
- win_cnt = cnt.

Optional Feature:
- Macro: SUM_WINDOW_AVG_EN.
- Defined: on completion, out_data <= (acc + x + 2^(WIN_LOG2-1)) >> WIN_LOG2. This is the rounded-half-up mean, zero-extended to ACC_W; upper WIN_LOG2 bits are always 0.
  - The rounding addend is 0 when WIN_LOG2 = 0.
  - Internal sum is computed at ACC_W+1 bits so the rounding addend cannot overflow.
- Undefined: out_data is the raw window sum. No rounding logic is present.

Test Plan:
- Reset/idle (N=10, WIN_LOG2=3): assert rst_n=0 mid-window after 3 samples, then release -> out_valid=0, out_data=0, win_cnt=0. The next 8 samples of value 5 give out_data=40.
- Max values: 8 samples in_sum=1023, in_co=1, in_valid held high, out_ready=1 -> one cycle after the 8th, out_valid=1, out_data=16376; in_ready stays 1 throughout.
- Back-pressure: out_ready=0 with the first window result pending; send 7 more samples of 1 -> all accepted, win_cnt=7. 8th sample: in_ready=0 until out_ready=1. Same cycle: in_ready=1, old result drains, new out_data=8 the next cycle.
- Simultaneous clr and accept at win_cnt=4 (sample 100) -> sample discarded, win_cnt=0, pending out_data/out_valid unchanged.
- Gapped input: in_valid toggling 1/0 with values 1..8 -> out_data=36 after the 8th accepted sample, exactly once.
- WIN_LOG2=0: stream 3, 7, 9 with out_ready=1 -> out_data 3, 7, 9 on consecutive cycles, each one cycle late.
- Average (SUM_WINDOW_AVG_EN defined, WIN_LOG2=3): samples summing to 36 -> out_data=5 (36+4=40, >>3); samples summing to 35 -> 4.
